// File: rtl/encoder_pkg.sv
// Shared constants for the 8-to-3 registered priority encoder.
// Holds the default widths and the register reset values.
package encoder_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  localparam logic [ENC_OUT_W-1:0] ENC_OUT_RST   = '0;
  localparam logic                 ENC_VALID_RST = 1'b0;
  localparam logic                 ENC_MULTI_RST = 1'b0;

endpackage : encoder_pkg

// File: rtl/encoder8_3_core.sv
// Combinational LSB-first priority encoder: index of lowest set bit,
// plus any-bit-set and more-than-one-bit-set flags.
module encoder8_3_core
  import encoder_pkg::*;
#(
  parameter  int IN_W  = ENC_IN_W,
  localparam int OUT_W = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out_n,
  output logic             valid_n,
  output logic             multi_n
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise the tool infers a latch.
    out_n = '0;
    // Scan from the top so the lowest set bit is the last (winning) write.
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (in[i]) begin
        out_n = OUT_W'(i);
      end
    end
  end

  assign valid_n = |in;
  // Clearing the lowest set bit leaves something only when two or more were set.
  assign multi_n = |(in & (in - IN_W'(1)));

endmodule : encoder8_3_core

// File: rtl/encoder8_3.sv
// Registered priority encoder: one-cycle latency from in to out/valid/multi,
// asynchronously cleared by an active-high reset.
module encoder8_3
  import encoder_pkg::*;
#(
  parameter  int IN_W  = ENC_IN_W,
  localparam int OUT_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             valid,
  output logic             multi
);

  logic [OUT_W-1:0] out_d,   out_q;
  logic             valid_d, valid_q;
  logic             multi_d, multi_q;

  encoder8_3_core #(
    .IN_W (IN_W)
  ) u_core (
    .in      (in),
    .out_n   (out_d),
    .valid_n (valid_d),
    .multi_n (multi_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= OUT_W'(ENC_OUT_RST);
      valid_q <= ENC_VALID_RST;
      multi_q <= ENC_MULTI_RST;
    end else begin
      // NOTE: non-blocking assignments so all three registers update together
      // from values computed before the edge.
      out_q   <= out_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign multi = multi_q;

endmodule : encoder8_3

// File: tb/tb_encoder8_3.sv
// Self-checking bench for encoder8_3: expectations are queued when an input is
// driven and compared at the falling edge after the DUT registers it.
module tb_encoder8_3;

  typedef struct packed {
    logic [2:0] out;
    logic       valid;
    logic       multi;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] in_r;
  logic [2:0] out;
  logic       valid;
  logic       multi;

  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  encoder8_3 dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in_r),
    .out   (out),
    .valid (valid),
    .multi (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] v);
    exp_t r;
    bit   found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (v[i] && !found) begin
        r.out = 3'(i);
        found = 1'b1;
      end
    end
    r.valid = (v != 8'h00);
    r.multi = ($countones(v) > 1);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_out"},   32'(out),   32'(e.out));
      check({tag, "_valid"}, 32'(valid), 32'(e.valid));
      check({tag, "_multi"}, 32'(multi), 32'(e.multi));
    end
  endtask

  // Drive v just after a rising edge; compare whatever that edge captured at
  // the following falling edge, when in already holds the new value.
  task automatic step(input string tag, input logic [7:0] v);
    bit have_cap;
    @(posedge clk);
    have_cap = (sb.size() > 0);
    #1;
    in_r = v;
    sb.push_back(model(v));
    @(negedge clk);
    if (have_cap) compare_front(tag);
  endtask

  task automatic flush(input string tag);
    @(posedge clk);
    @(negedge clk);
    while (sb.size() > 0) compare_front(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Asynchronous reset before any clock edge.
    rst  = 1'b1;
    in_r = 8'hFF;
    #2;
    check("rst_out",   32'(out),   32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_multi", 32'(multi), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    sb.push_back(model(8'hFF));

    // One-hot sweep; the first step also checks the post-release 8'hFF capture.
    for (int i = 0; i < 8; i++) step("onehot", 8'(1 << i));

    step("multi_68", 8'b0110_1000);
    step("multi_81", 8'b1000_0001);
    step("multi_c0", 8'b1100_0000);
    step("empty",    8'h00);
    step("bit0",     8'h01);

    for (int i = 0; i < 1000; i++) step("rand", 8'($urandom % 256));

    // Mid-stream reset pulse between edges.
    step("pre_rst", 8'h0C);
    flush("pre_rst");
    rst = 1'b1;
    #1;
    check("mid_rst_out",   32'(out),   32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_multi", 32'(multi), 32'd0);
    in_r = 8'h28;
    sb.delete();
    sb.push_back(model(8'h28));
    #1;
    rst = 1'b0;
    step("post_rst", 8'h40);
    flush("tail");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_encoder8_3
